// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse cipher datapath.
// Holds the forward/inverse S-box lookups, Rcon table, GF(2^8) arithmetic,
// forward and inverse key-schedule steps and the one-hot FSM encoding.
package aes_pkg;

    localparam int NB_COLS = 4;

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        KEYX  = 6'b000010,
        INIT  = 6'b000100,
        ROUND = 6'b001000,
        FINAL = 6'b010000,
        DONE  = 6'b100000
    } fsm_t;

    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Entry 0 occupies the top byte.
    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [2047:0] ISBOX_T = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_T[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] x);
        return ISBOX_T[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [7:0] r);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {r, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one forward step: recover the previous round key from the next one.
    function automatic logic [127:0] key_step_inv(input logic [127:0] k, input logic [7:0] r);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {r, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational inverse AES round.
//   state_in  : current state (byte 0 at [127:120], column-major)
//   rkey      : round key for AddRoundKey
//   final_rnd : 1 = skip InvMixColumns (last round)
//   state_out : InvMixColumns(InvSubBytes(InvShiftRows(state_in)) ^ rkey)
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rkey,
    input  logic         final_rnd,
    output logic [127:0] state_out
);

    logic [127:0] ark;

    for (genvar c = 0; c < NB_COLS; c++) begin : g_col
        // InvShiftRows: row r of column c comes from column (c - r) mod 4.
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign ark[127-8*(r+4*c) -: 8] =
                isbox(state_in[127-8*(r+4*((c+4-r)%4)) -: 8]) ^ rkey[127-8*(r+4*c) -: 8];
        end

        logic [7:0] a0, a1, a2, a3;
        logic [31:0] mixed;
        assign a0 = ark[127-32*c -: 8];
        assign a1 = ark[119-32*c -: 8];
        assign a2 = ark[111-32*c -: 8];
        assign a3 = ark[103-32*c -: 8];
        assign mixed = {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        assign state_out[127-32*c -: 32] = final_rnd ? ark[127-32*c -: 32] : mixed;
    end

endmodule

// File: rtl/aes128_inv_cipher_seq.sv
// Iterative AES-128 decryptor, one round per clock, with a one-entry
// cache of the last expanded key (k10) so a repeated key skips expansion.
//   clk, rst              : clock, async active-high reset
//   in_valid/in_ready     : ciphertext + key handshake (ready only in IDLE)
//   in_data, in_key       : 128-bit ciphertext / key, byte 0 at [127:120]
//   out_valid/out_ready   : plaintext handshake, held until accepted
//   out_data              : 128-bit plaintext
//   busy                  : FSM not in IDLE
module aes128_inv_cipher_seq
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (NR != 10) begin : g_nr_chk
        $fatal(1, "aes128_inv_cipher_seq: NR must be 10");
    end

    fsm_t         st;
    logic [127:0] state_q, key_q;
    logic [3:0]   cnt;
    logic [127:0] cached_key, cached_k10;
    logic         cache_vld;
    logic [127:0] rnd_out, key_fwd;
    logic [3:0]   cnt_m1;

    assign in_ready = (st == IDLE);
    assign busy     = (st != IDLE);
    assign key_fwd  = key_step_fwd(key_q, RCON[cnt]);
    assign cnt_m1   = cnt - 4'd1;

    aes_inv_round u_rnd (
        .state_in  (state_q),
        .rkey      (key_q),
        .final_rnd (st == FINAL),
        .state_out (rnd_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            state_q    <= '0;
            key_q      <= '0;
            cnt        <= '0;
            cached_key <= '0;
            cached_k10 <= '0;
            cache_vld  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            case (st)
                IDLE: if (in_valid) begin
                    state_q <= in_data;
                    key_q   <= in_key;
                    cnt     <= '0;
                    if (cache_vld && in_key == cached_key) begin
                        st <= INIT;
                    end else begin
                        // The entry is invalid while expansion runs, so the tag can be
                        // captured now instead of keeping a separate copy of the key.
                        cached_key <= in_key;
                        cache_vld  <= 1'b0;
                        st         <= KEYX;
                    end
                end
                KEYX: begin
                    key_q <= key_fwd;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd9) begin
                        cached_k10 <= key_fwd;
                        cache_vld  <= 1'b1;
                        st         <= INIT;
                    end
                end
                // cached_k10 is current on both hit and miss paths.
                INIT: begin
                    state_q <= state_q ^ cached_k10;
                    key_q   <= key_step_inv(cached_k10, RCON[9]);
                    cnt     <= 4'd9;
                    st      <= ROUND;
                end
                ROUND: begin
                    state_q <= rnd_out;
                    key_q   <= key_step_inv(key_q, RCON[cnt_m1]);
                    cnt     <= cnt_m1;
                    if (cnt == 4'd1) st <= FINAL;
                end
                FINAL: begin
                    out_data  <= rnd_out;
                    out_valid <= 1'b1;
                    st        <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    st        <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_inv_cipher_seq.sv
module tb_aes128_inv_cipher_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, in_key, out_data;

    aes128_inv_cipher_seq #(.NR(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: forward AES-128 from first principles
    logic [7:0] msb [256];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box = affine(a^254) over GF(2^8)
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] a, inv;
            a = 8'(v);
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gm(inv, a);
            msb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                     {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] m_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {msb[tmp[23:16]], msb[tmp[15:8]], msb[tmp[7:0]], msb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int rnd = 0; rnd <= 10; rnd++) begin
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) t[i] = msb[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
                if (rnd < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        logic [7:0] a0, a1, a2, a3;
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                        s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[4*rnd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // one-entry cache as seen from outside
    logic [127:0] mkey;
    bit           mvld = 1'b0;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Submit one block, check latency/plaintext, optionally stall out_ready.
    task automatic run(input string tag, input logic [127:0] key, input logic [127:0] ct,
                       input logic [127:0] exp, input int exp_lat, input int hold, input bit rdy_early);
        int lat;
        lat = 0;
        while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({tag, "_inrdy"}, 128'(in_ready), 128'd1);
        in_valid  = 1'b1;
        in_data   = ct;
        in_key    = key;
        out_ready = rdy_early;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 60) begin
            // junk offered mid-operation must be ignored
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rnd128();
            in_key   = rnd128();
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_pt"}, out_data, exp);
        if (!rdy_early) begin
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = rnd128();
                in_key   = rnd128();
                @(posedge clk); #1;
                chk({tag, "_hold_vld"}, 128'(out_valid), 128'd1);
                chk({tag, "_hold_pt"}, out_data, exp);
                chk({tag, "_hold_inrdy"}, 128'(in_ready), 128'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_vld_clr"}, 128'(out_valid), 128'd0);
        chk({tag, "_idle"}, 128'(in_ready), 128'd1);
        mkey = key;
        mvld = 1'b1;
    endtask

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        logic [127:0] k, p;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inrdy", 128'(in_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ovld", 128'(out_valid), 128'd0);
        chk("rst_odata", out_data, 128'd0);
        @(negedge clk) rst = 1'b0;

        chk("model_c1", m_encrypt(K1, P1), C1);
        chk("model_c2", m_encrypt(K2, P2), C2);

        run("c1_miss", K1, C1, P1, 21, 0, 1'b0);
        run("c1_hit", K1, C1, P1, 11, 0, 1'b0);
        run("c2_miss", K2, C2, P2, 21, 0, 1'b0);
        run("c1_hold", K1, C1, P1, 21, 5, 1'b0);
        run("c1_hit2", K1, C1, P1, 11, 0, 1'b1);

        // abort during key expansion: outputs drop to reset values at once
        in_valid = 1'b1; in_data = C2; in_key = K2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_inrdy", 128'(in_ready), 128'd1);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_ovld", 128'(out_valid), 128'd0);
        chk("abort_odata", out_data, 128'd0);
        @(negedge clk) rst = 1'b0;
        mvld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_noout", 128'(out_valid), 128'd0);
        run("c1_after_rst", K1, C1, P1, 21, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            k = (!mvld || $urandom_range(0, 1) == 0) ? rnd128() : mkey;
            p = rnd128();
            run($sformatf("rnd%0d", i), k, m_encrypt(k, p), p,
                (mvld && k == mkey) ? 11 : 21, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes128_inv_cipher_seq.md
AES128_INV_CIPHER_SEQ -- requirements
Module: aes128_inv_cipher_seq

Interface
REQ-001 The block SHALL have one parameter: NR, default 10, number of AES rounds; only 10 is legal, and elaboration SHALL fail for any other value.
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port rst SHALL be an input, 1 bit: reset, asynchronous, active-high.
REQ-004 Port in_valid SHALL be an input, 1 bit: ciphertext and key offered.
REQ-005 Port in_ready SHALL be an output, 1 bit: the block can accept a new block.
REQ-006 Port in_data SHALL be an input, 128 bits: ciphertext, byte 0 at bits [127:120].
REQ-007 Port in_key SHALL be an input, 128 bits: cipher key, same byte order as in_data.
REQ-008 Port out_valid SHALL be an output, 1 bit: plaintext available.
REQ-009 Port out_ready SHALL be an input, 1 bit: downstream accepts the plaintext.
REQ-010 Port out_data SHALL be an output, 128 bits: plaintext.
REQ-011 Port busy SHALL be an output, 1 bit: high in every state except IDLE.

Function
REQ-012 The block SHALL use a one-hot FSM with states IDLE, KEYX, INIT, ROUND, FINAL and DONE.
REQ-013 in_ready SHALL equal (state == IDLE); an input transfer SHALL occur on any edge where in_valid and in_ready are both high.
REQ-014 On accept, the block SHALL latch in_data into the state register and in_key into the key register.
REQ-015 On accept, the block SHALL go to INIT if cache_vld is set and in_key equals cached_key, otherwise to KEYX.
REQ-016 KEYX SHALL run exactly 10 cycles of forward key expansion, one round key per cycle, Rcon 01,02,04,08,10,20,40,80,1B,36.
REQ-017 On the 10th KEYX cycle, the block SHALL store k10 into cached_k10, store in_key into cached_key, set cache_vld and go to INIT.
REQ-018 INIT SHALL take one cycle: state <= state XOR k10, key <= inverse key step of k10 (= k9), round counter <= 9.
REQ-019 Inverse key step with Rcon r SHALL be: w3' = w3^w2; w2' = w2^w1; w1' = w1^w0; w0' = w0 ^ SubWord(RotWord(w3')) ^ r.
REQ-020 ROUND SHALL take one cycle per round i = 9 down to 1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ ki), key <= k(i-1); the block SHALL go to FINAL after i = 1.
REQ-021 FINAL SHALL take one cycle: out_data <= InvSubBytes(InvShiftRows(state)) ^ k0, out_valid <= 1, go to DONE.
REQ-022 Latency from the accept edge to out_valid high SHALL be 21 cycles on a cache miss and 11 cycles on a cache hit.
REQ-023 In DONE, out_valid and out_data SHALL hold stable until out_ready is high; on that edge out_valid SHALL clear and the FSM SHALL return to IDLE, so back-to-back accept is one cycle later.
REQ-024 in_valid asserted in any state other than IDLE SHALL be ignored and SHALL not corrupt the operation in progress.
REQ-025 out_ready while out_valid is low SHALL have no effect.
REQ-026 A cache miss SHALL overwrite the cache; the cache SHALL hold one entry only.
REQ-027 All XOR and S-box arithmetic SHALL be GF(2^8) bytewise; no carries.

Reset
REQ-028 Reset SHALL put the FSM in IDLE, with in_ready=1, busy=0, out_valid=0 and out_data=0.
REQ-029 Reset SHALL clear the state register, key register, counter, cached_key, cached_k10 and cache_vld.
REQ-030 Reset asserted mid-operation SHALL abort the block with no output produced, and the next block SHALL be treated as a cache miss.

Structure
REQ-031 The shared package aes_pkg SHALL hold the forward S-box and inverse S-box tables as functions, the Rcon table, the xtime/GF-multiply functions and the FSM state encoding.
REQ-032 A combinational sub-module aes_inv_round SHALL implement InvShiftRows, InvSubBytes, AddRoundKey and an optional InvMixColumns, selected by a final-round input.
REQ-033 The inverse key step SHALL be a package function.

Verification
REQ-034 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f with ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 21 cycles after accept.
REQ-035 The same key with the same ciphertext immediately resubmitted -> identical plaintext after 11 cycles (cache hit).
REQ-036 Key change to 2b7e151628aed2a6abf7158809cf4f3c with ciphertext 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734 with 21-cycle latency.
REQ-037 out_ready held low for 5 cycles in DONE -> out_valid and out_data stable; in_ready stays 0; in_valid pulses are ignored.
REQ-038 rst pulsed on cycle 6 of KEYX -> all outputs at reset values immediately; the C.1 resubmission then completes in 21 cycles with the correct plaintext.
